// File: rtl/grng_sample_fifo.sv
// Consumer-side front end for the CLT Gaussian generator: sequences its init/prime
// window, advances it on credit only, and buffers fresh samples in a small FIFO.
module grng_sample_fifo #(
    parameter int DEPTH       = 4,
    parameter int INIT_CYCLES = 5,
    parameter int PRIME       = 2,
    parameter int DATA_W      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     gen_resetn,
    output logic                     gen_enable,
    input  logic [DATA_W-1:0]        gen_sample,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     primed
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int CNT_MAX = (INIT_CYCLES > PRIME) ? INIT_CYCLES : PRIME;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        WAIT_INIT,
        PRIME_S,
        RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       phase_cnt;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                capture_pending;
    logic                pop;
    logic                push;
    logic                flush_run;
    logic [LW:0]         credit_used;
    logic [DATA_W-1:0]   mem [DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_INIT;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_INIT: if (phase_cnt == CW'(INIT_CYCLES - 1)) state_next = PRIME_S;
            PRIME_S:   if (phase_cnt == CW'(PRIME - 1))       state_next = RUN;
            RUN:       state_next = RUN;
            default:   state_next = WAIT_INIT;
        endcase
    end

    // One counter times both the init and prime windows; it restarts on every transition.
    always_ff @(posedge clk) begin
        if (reset || (state != state_next)) phase_cnt <= '0;
        else if (state != RUN)              phase_cnt <= phase_cnt + 1'b1;
    end

    // Credit counts stored entries plus the sample already in flight, minus this cycle's pop.
    always_comb begin
        pop         = out_valid && out_ready;
        flush_run   = flush && (state == RUN);
        push        = capture_pending && !flush_run;
        credit_used = (LW+1)'(level) + (LW+1)'(capture_pending) - (LW+1)'(pop);
        gen_enable  = 1'b0;
        if (!reset) begin
            if (state == PRIME_S)
                gen_enable = 1'b1;
            else if (state == RUN && !flush_run)
                gen_enable = (credit_used < (LW+1)'(DEPTH));
        end
        primed     = (state == RUN);
        gen_resetn = !reset;
        out_valid  = (level != '0);
        out_data   = out_valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset || flush_run) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            capture_pending <= 1'b0;
        end else begin
            capture_pending <= gen_enable && (state == RUN);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // NOTE: storage is left unreset; out_data is masked by out_valid so stale entries never show.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= gen_sample;
    end

endmodule
